// File: rtl/fpa_share_arbiter.sv
// Round-robin arbiter sharing one pipelined FP add/sub unit between two requesters.
// A tag pipeline tracks in-flight ownership and steers results into per-requester FIFOs.
module fpa_share_arbiter #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic        Clk,
  input  logic        Clear,
  input  logic        Req0_Valid,
  output logic        Req0_Ready,
  input  logic [31:0] Req0_OpA,
  input  logic [31:0] Req0_OpB,
  input  logic        Req0_Sub,
  input  logic [1:0]  Req0_Rm,
  input  logic        Req1_Valid,
  output logic        Req1_Ready,
  input  logic [31:0] Req1_OpA,
  input  logic [31:0] Req1_OpB,
  input  logic        Req1_Sub,
  input  logic [1:0]  Req1_Rm,
  output logic [31:0] Fpa_OpA,
  output logic [31:0] Fpa_OpB,
  output logic        Fpa_Sub_Signal,
  output logic [1:0]  Fpa_Rm,
  output logic        Fpa_Value_In,
  input  logic [31:0] Fpa_Result,
  input  logic        Fpa_Value_Out,
  output logic        Rsp0_Valid,
  input  logic        Rsp0_Ready,
  output logic [31:0] Rsp0_Data,
  output logic        Rsp1_Valid,
  input  logic        Rsp1_Ready,
  output logic [31:0] Rsp1_Data,
  output logic        Busy,
  output logic        Err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CREDIT_ONE = CW'(1);
  localparam logic [AW:0]   PTR_ONE    = (AW + 1)'(1);

  logic [1:0]         w_reqValid;
  logic [1:0]         w_rspReady;
  logic [1:0]         w_elig;
  logic [1:0]         w_grant;
  logic [1:0]         w_rspValid;
  logic [1:0]         w_full;
  logic [1:0]         w_push;
  logic [1:0]         w_pop;
  logic               w_handshake;
  logic               w_retValid;
  logic               w_retOwner;

  logic [CW-1:0]      r_credit [2];
  logic               r_last;
  logic [31:0]        r_opA;
  logic [31:0]        r_opB;
  logic               r_sub;
  logic [1:0]         r_rm;
  logic               r_issueValid;
  logic               r_issueOwner;
  logic [LATENCY-1:0] r_tagValid;
  logic [LATENCY-1:0] r_tagOwner;
  logic [31:0]        r_mem [2][DEPTH];
  logic [AW:0]        r_wptr [2];
  logic [AW:0]        r_rptr [2];
  logic               r_err;

  assign w_reqValid = {Req1_Valid, Req0_Valid};
  assign w_rspReady = {Rsp1_Ready, Rsp0_Ready};
  assign w_retValid = r_tagValid[LATENCY-1];
  assign w_retOwner = r_tagOwner[LATENCY-1];

  for (genvar g = 0; g < 2; g++) begin : g_req
    assign w_elig[g]     = w_reqValid[g] && (r_credit[g] < CREDIT_MAX);
    assign w_rspValid[g] = (r_wptr[g] != r_rptr[g]);
    assign w_full[g]     = (r_wptr[g][AW] != r_rptr[g][AW]) &&
                           (r_wptr[g][AW-1:0] == r_rptr[g][AW-1:0]);
    assign w_pop[g]      = w_rspValid[g] && w_rspReady[g];
    assign w_push[g]     = w_retValid && (w_retOwner == 1'(g)) && !w_full[g];
  end

  // On a tie the requester opposite the last winner takes the adder.
  assign w_grant[0]  = w_elig[0] && (!w_elig[1] || r_last);
  assign w_grant[1]  = w_elig[1] && (!w_elig[0] || !r_last);
  assign w_handshake = |w_grant;

  assign Req0_Ready = w_grant[0];
  assign Req1_Ready = w_grant[1];

  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      r_issueValid <= 1'b0;
      r_issueOwner <= 1'b0;
      r_last       <= 1'b1;
      r_opA        <= '0;
      r_opB        <= '0;
      r_sub        <= 1'b0;
      r_rm         <= '0;
    end else begin
      r_issueValid <= w_handshake;
      if (w_handshake) begin
        r_issueOwner <= w_grant[1];
        r_last       <= w_grant[1];
        r_opA        <= w_grant[1] ? Req1_OpA : Req0_OpA;
        r_opB        <= w_grant[1] ? Req1_OpB : Req0_OpB;
        r_sub        <= w_grant[1] ? Req1_Sub : Req0_Sub;
        r_rm         <= w_grant[1] ? Req1_Rm  : Req0_Rm;
      end
    end
  end

  // Stage k of the tag pipe lines up with the adder's k-th pipeline stage.
  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      r_tagValid <= '0;
      r_tagOwner <= '0;
    end else begin
      r_tagValid[0] <= r_issueValid;
      r_tagOwner[0] <= r_issueOwner;
      for (int k = 1; k < LATENCY; k++) begin
        r_tagValid[k] <= r_tagValid[k-1];
        r_tagOwner[k] <= r_tagOwner[k-1];
      end
    end
  end

  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      for (int i = 0; i < 2; i++) begin
        r_wptr[i]   <= '0;
        r_rptr[i]   <= '0;
        r_credit[i] <= '0;
        for (int j = 0; j < DEPTH; j++) begin
          r_mem[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_push[i]) begin
          r_mem[i][r_wptr[i][AW-1:0]] <= Fpa_Result;
          r_wptr[i]                   <= r_wptr[i] + PTR_ONE;
        end
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + PTR_ONE;
        end
        case ({w_grant[i], w_pop[i]})
          2'b10:   r_credit[i] <= r_credit[i] + CREDIT_ONE;
          2'b01:   r_credit[i] <= r_credit[i] - CREDIT_ONE;
          default: r_credit[i] <= r_credit[i];
        endcase
      end
    end
  end

  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | (Fpa_Value_Out != w_retValid) | (w_retValid && w_full[w_retOwner]);
    end
  end

  assign Fpa_OpA        = r_opA;
  assign Fpa_OpB        = r_opB;
  assign Fpa_Sub_Signal = r_sub;
  assign Fpa_Rm         = r_rm;
  assign Fpa_Value_In   = r_issueValid;

  assign Rsp0_Valid = w_rspValid[0];
  assign Rsp1_Valid = w_rspValid[1];
  assign Rsp0_Data  = r_mem[0][r_rptr[0][AW-1:0]];
  assign Rsp1_Data  = r_mem[1][r_rptr[1][AW-1:0]];

  assign Busy = (|r_tagValid) | r_issueValid | (|w_rspValid);
  assign Err  = r_err;

endmodule
